// File: rtl/reg_file_dc.sv
// Decode-stage register file: one writeback port, two registered read ports,
// with write-to-read bypass and operand refresh while the output is stalled.
module reg_file_dc #(
    parameter int DATA_W = 16,
    parameter int N_REGS = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK_DC,
    input  logic              RST_DC,
    input  logic              VALID_IN,
    input  logic              STALL,
    input  logic [ADDR_W-1:0] N_REG_A_IN,
    input  logic [ADDR_W-1:0] N_REG_B_IN,
    input  logic              WE,
    input  logic [ADDR_W-1:0] N_REG_W,
    input  logic [DATA_W-1:0] REG_W_DATA,
    output logic              VALID_OUT,
    output logic [ADDR_W-1:0] N_REG_A_OUT,
    output logic [ADDR_W-1:0] N_REG_B_OUT,
    output logic [DATA_W-1:0] REG_A_OUT,
    output logic [DATA_W-1:0] REG_B_OUT
);

    logic [DATA_W-1:0] regs_q [N_REGS];

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] a_idx_q, a_idx_d;
    logic [ADDR_W-1:0] b_idx_q, b_idx_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    logic              w_ok;

    // Explicit scan keeps non-power-of-two N_REGS free of wide compares.
    function automatic logic in_range(
        input logic [ADDR_W-1:0] idx
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (idx == ADDR_W'(i)) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] rd(
        input logic [ADDR_W-1:0] idx
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (idx == ADDR_W'(i)) begin
                r = regs_q[i];
            end
        end
        return r;
    endfunction

    assign w_ok = WE && in_range(N_REG_W);

    always_comb begin
        valid_d = valid_q;
        a_idx_d = a_idx_q;
        b_idx_d = b_idx_q;
        a_d     = a_q;
        b_d     = b_q;
        if (!STALL) begin
            valid_d = VALID_IN;
            a_idx_d = N_REG_A_IN;
            b_idx_d = N_REG_B_IN;
            if (w_ok && N_REG_W == N_REG_A_IN) begin
                a_d = REG_W_DATA;
            end else begin
                a_d = rd(N_REG_A_IN);
            end
            if (w_ok && N_REG_W == N_REG_B_IN) begin
                b_d = REG_W_DATA;
            end else begin
                b_d = rd(N_REG_B_IN);
            end
        end else begin
            // A held instruction picks up writes to its own operands.
            if (w_ok && N_REG_W == a_idx_q) begin
                a_d = REG_W_DATA;
            end
            if (w_ok && N_REG_W == b_idx_q) begin
                b_d = REG_W_DATA;
            end
        end
    end

    always_ff @(posedge CLK_DC) begin
        if (RST_DC) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REGS; i++) begin
                if (WE && N_REG_W == ADDR_W'(i)) begin
                    regs_q[i] <= REG_W_DATA;
                end
            end
        end
    end

    always_ff @(posedge CLK_DC) begin
        if (RST_DC) begin
            valid_q <= 1'b0;
            a_idx_q <= '0;
            b_idx_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            valid_q <= valid_d;
            a_idx_q <= a_idx_d;
            b_idx_q <= b_idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign VALID_OUT   = valid_q;
    assign N_REG_A_OUT = a_idx_q;
    assign N_REG_B_OUT = b_idx_q;
    assign REG_A_OUT   = a_q;
    assign REG_B_OUT   = b_q;

endmodule
